// File: rtl/neopix_pkg.sv
// ----------------------------------------------------------------------------
// neopix_pkg
// Shared definitions for the WS2812 (NeoPixel) transmit path.
//   - Default pulse timing in 50 MHz clock cycles.
//   - Transmit FSM state encoding.
// ----------------------------------------------------------------------------
package neopix_pkg;

    localparam int T0H_CYC_DEF  = 20;    // '0' bit high time, 0.40 us
    localparam int T1H_CYC_DEF  = 40;    // '1' bit high time, 0.80 us
    localparam int TBIT_CYC_DEF = 63;    // full bit period, 1.26 us
    localparam int TRST_CYC_DEF = 2600;  // latch low time, 52 us

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIT   = 2'd1,
        LATCH = 2'd2
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
// Synchronous show-ahead FIFO: data_o always presents the oldest entry while
// empty_o is low, so a consumer can use it in the same cycle it pops.
// A push into a full FIFO is accepted only when a pop happens in that cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset (discards contents)
//   push_i     write data_i
//   pop_i      discard the head entry (ignored while empty)
//   data_o     head entry
//   full_o     DEPTH entries stored
//   empty_o    no entries stored
//   count_o    number of entries stored (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A slot freed by a same-cycle pop can take the incoming byte.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ws2812_tx.sv
// ----------------------------------------------------------------------------
// ws2812_tx
// Buffers SPI-received bytes and serialises them MSB-first onto the WS2812
// data line with pulse-width coding; a frame end appends the latch low time.
// Ports:
//   clk, rst     50 MHz clock, synchronous active-high reset
//   byte_data    received byte, qualified by byte_valid (no backpressure)
//   byte_valid   one-cycle strobe, pushes byte_data into the FIFO
//   frame_end    one-cycle strobe at SSEL rising edge, requests a latch
//   dout         WS2812 data line (registered)
//   busy         FIFO non-empty, FSM not idle, or latch pending
//   overflow     sticky: a byte was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module ws2812_tx
    import neopix_pkg::*;
#(
    parameter int T0H_CYC    = T0H_CYC_DEF,
    parameter int T1H_CYC    = T1H_CYC_DEF,
    parameter int TBIT_CYC   = TBIT_CYC_DEF,
    parameter int TRST_CYC   = TRST_CYC_DEF,
    parameter int FIFO_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       frame_end,
    output logic       dout,
    output logic       busy,
    output logic       overflow
);

    localparam int CNT_MAX = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(TBIT_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(TRST_CYC - 1);
    localparam logic [CNT_W-1:0] T0H_LIM  = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H_LIM  = CNT_W'(T1H_CYC);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             latch_q, latch_d;
    logic             overflow_q, overflow_d;
    logic             dout_q, dout_d;
    logic             latch_clr;
    logic [CNT_W-1:0] high_lim;

    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (byte_valid),
        .data_i  (byte_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        latch_clr = 1'b0;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                // Pending data always goes out before a pending latch.
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_rdata;
                    bit_idx_d = 3'd7;
                    cnt_d     = '0;
                    state_d   = BIT;
                end else if (latch_q) begin
                    latch_clr = 1'b1;
                    cnt_d     = '0;
                    state_d   = LATCH;
                end
            end
            BIT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q != 3'd0) begin
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_idx_d = bit_idx_q - 3'd1;
                    end else if (!fifo_empty) begin
                        // Reload straight from the FIFO so byte boundaries
                        // keep the exact bit period.
                        fifo_pop  = 1'b1;
                        shreg_d   = fifo_rdata;
                        bit_idx_d = 3'd7;
                    end else if (latch_q) begin
                        latch_clr = 1'b1;
                        state_d   = LATCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LATCH: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A frame_end in the same cycle the latch starts is a new request.
        latch_d    = (latch_q && !latch_clr) || frame_end;
        overflow_d = overflow_q || (byte_valid && fifo_full && !fifo_pop);

        // Output is computed from next state so the line is registered
        // without adding a cycle of latency.
        high_lim = shreg_d[7] ? T1H_LIM : T0H_LIM;
        dout_d   = (state_d == BIT) && (cnt_d < high_lim);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            latch_q    <= 1'b0;
            overflow_q <= 1'b0;
            dout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            latch_q    <= latch_d;
            overflow_q <= overflow_d;
            dout_q     <= dout_d;
        end
    end

    assign dout     = dout_q;
    assign overflow = overflow_q;
    assign busy     = (fifo_count != '0) || (state_q != IDLE) || latch_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// ----------------------------------------------------------------------------
// tb_ws2812_tx
// Scoreboard bench: stimulus pushes expected line tokens (bits MSB-first,
// latches) into a queue; a monitor decodes pulses and latch periods from
// dout/busy and pops/compares them independently of the stimulus.
// ----------------------------------------------------------------------------
module tb_ws2812_tx;

    localparam int T0H   = 20;
    localparam int T1H   = 40;
    localparam int TBIT  = 63;
    localparam int TRST  = 2600;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       frame_end = 1'b0;
    logic       dout;
    logic       busy;
    logic       overflow;

    ws2812_tx #(
        .T0H_CYC    (T0H),
        .T1H_CYC    (T1H),
        .TBIT_CYC   (TBIT),
        .TRST_CYC   (TRST),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_end  (frame_end),
        .dout       (dout),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    // contig: this bit must start exactly one bit period after the previous one
    typedef struct packed {
        logic is_latch;
        logic val;
        logic contig;
    } tok_t;

    tok_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // monitor state
    int   mon_cyc  = 0;
    int   mon_rise = -100000;
    int   mon_hi   = 0;
    int   mon_run  = 0;
    int   mon_dist = 0;
    bit   mon_prev = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_byte(input logic [7:0] b, input bit contig);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back('{1'b0, b[i], (i != 7) || contig});
        end
    endtask

    task automatic model_latch();
        exp_q.push_back('{1'b1, 1'b0, 1'b0});
    endtask

    // ---------------- monitor ----------------
    task automatic end_pulse(input int h, input int d);
        tok_t t;
        int   v;
        v = (h == T1H) ? 1 : ((h == T0H) ? 0 : 2);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pulse: width %0d, no bit expected", h);
            return;
        end
        t = exp_q.pop_front();
        if (t.is_latch) begin
            checks++;
            errors++;
            $display("FAIL order: got bit (width %0d), required latch", h);
            return;
        end
        check($sformatf("bit_value(h=%0d)", h), v, int'(t.val));
        if (t.contig) check("bit_period", d, TBIT);
    endtask

    task automatic end_run(input int len);
        tok_t t;
        int   k;
        int   r;
        k = len / TRST;
        r = len - k * TRST;
        for (int i = 0; i < k; i++) begin
            checks++;
            if (exp_q.size() == 0 || !exp_q[0].is_latch) begin
                errors++;
                $display("FAIL latch: got latch (low run %0d), required none", len);
            end else begin
                t = exp_q.pop_front();
                $display("ok   latch seen (low run %0d)", len);
            end
        end
        // k latches separated by one idle cycle, plus at most one lead cycle
        if (k > 0) check($sformatf("latch_len(run=%0d)", len), int'(r >= k - 1 && r <= k + 1), 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_cyc++;
                if (dout && !mon_prev) begin
                    mon_dist = mon_cyc - mon_rise;
                    mon_rise = mon_cyc;
                    mon_hi   = 0;
                end
                if (dout) mon_hi++;
                if (!dout && mon_prev) end_pulse(mon_hi, mon_dist);
                if (!dout && busy && (mon_cyc - mon_rise) >= TBIT) begin
                    mon_run++;
                end else if (mon_run > 0) begin
                    end_run(mon_run);
                    mon_run = 0;
                end
                mon_prev = dout;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [7:0] d, input bit fe);
        byte_valid = v;
        byte_data  = d;
        frame_end  = fe;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        frame_end  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    int         nb;
    int         fe_dly;
    bit         spaced;
    bit         last;
    logic [7:0] d;
    int         n;
    int         highs;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        idle_cycles(5);

        // 0xAA then frame_end; idle latency: busy next cycle, dout two cycles on
        byte_data  = 8'hAA;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        model_byte(8'hAA, 1'b0);
        check("latency_n1_dout", int'(dout), 0);
        check("latency_n1_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        check("latency_n2_dout", int'(dout), 1);
        drive(1'b0, 8'h00, 1'b1);
        model_latch();
        wait_idle("idle_after_aa", 6000);

        // three bytes at SPI pace (800 cycles), underrun between them
        drive(1'b1, 8'hAA, 1'b0); model_byte(8'hAA, 1'b0); idle_cycles(799);
        drive(1'b1, 8'h55, 1'b0); model_byte(8'h55, 1'b0); idle_cycles(799);
        drive(1'b1, 8'h00, 1'b0); model_byte(8'h00, 1'b0); idle_cycles(10);
        drive(1'b0, 8'h00, 1'b1); model_latch();
        wait_idle("idle_after_3bytes", 8000);

        // byte coincident with frame_end: byte goes out before the latch
        drive(1'b1, 8'hFF, 1'b1);
        model_byte(8'hFF, 1'b0);
        model_latch();
        wait_idle("idle_after_ff_fe", 6000);

        // frame_end on empty FIFO, second one mid-latch -> two latches
        drive(1'b0, 8'h00, 1'b1); model_latch();
        idle_cycles(1000);
        drive(1'b0, 8'h00, 1'b1); model_latch();
        wait_idle("idle_after_double_latch", 8000);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            nb     = $urandom_range(1, 3);
            spaced = 1'($urandom_range(0, 1));
            fe_dly = $urandom_range(0, 200);
            $display("frame %0d: %0d bytes, spaced=%0d, frame_end delay %0d", f, nb, spaced, fe_dly);
            for (int b = 0; b < nb; b++) begin
                d    = 8'($urandom);
                last = (b == nb - 1);
                drive(1'b1, d, last && (fe_dly == 0));
                model_byte(d, !spaced && (b != 0));
                if (spaced && !last) idle_cycles(799);
            end
            if (fe_dly != 0) begin
                idle_cycles(fe_dly);
                drive(1'b0, 8'h00, 1'b1);
            end
            model_latch();
            wait_idle("idle_after_random_frame", 12000);
        end

        // overflow: the first byte moves into the shift register the cycle
        // after it lands, so DEPTH+1 consecutive bytes fit and the next drops.
        check("ovf_before", int'(overflow), 0);
        for (int i = 0; i < 70; i++) begin
            d          = 8'($urandom);
            byte_data  = d;
            byte_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i <= DEPTH) model_byte(d, i != 0);
            if (i == DEPTH) check("ovf_last_accepted", int'(overflow), 0);
            if (i == DEPTH + 1) check("ovf_first_dropped", int'(overflow), 1);
        end
        byte_valid = 1'b0;
        wait_idle("idle_after_overflow", 40000);
        check("ovf_sticky", int'(overflow), 1);

        idle_cycles(5);
        check("scoreboard_drained", exp_q.size(), 0);

        // reset in the middle of a '1' bit with a second byte still queued
        mon_en = 1'b0;
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        n = 0;
        while (!dout && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle_cycles(29);
        check("pre_rst_dout_high", int'(dout), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_dout", int'(dout), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        rst   = 1'b0;
        highs = 0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            #1;
            if (dout) highs++;
        end
        check("no_pulse_after_rst", highs, 0);
        check("busy_after_rst", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
